// File: rtl/drive_arbiter_pkg.sv
// drive_arbiter_pkg: shared states, source indices and wheel-command width
package drive_arbiter_pkg;
  localparam int WHEEL_W = 8;
  typedef enum logic [1:0] {IDLE, RUN, SWITCH, FAULT} state_t;
  localparam logic [1:0] SRC_MANUAL = 2'd0;
  localparam logic [1:0] SRC_AVOID  = 2'd1;
  localparam logic [1:0] SRC_CRUISE = 2'd2;
  localparam logic [1:0] SRC_NONE   = 2'd3;
endpackage

// File: rtl/drive_arbiter_if.sv
// drive_arbiter_if: controller requests/commands in, grant and wheel commands out
interface drive_arbiter_if #(parameter int W = drive_arbiter_pkg::WHEEL_W);
  logic                run;
  logic [2:0]          src_req;
  logic [2:0]          src_valid;
  logic signed [W-1:0] cmd_left_0, cmd_left_1, cmd_left_2;
  logic signed [W-1:0] cmd_right_0, cmd_right_1, cmd_right_2;
  logic [2:0]          src_enable;
  logic signed [W-1:0] wheel_left, wheel_right;
  logic [1:0]          active_src;
  logic                fault;
  modport master (
    output run, src_req, src_valid, cmd_left_0, cmd_left_1, cmd_left_2,
           cmd_right_0, cmd_right_1, cmd_right_2,
    input  src_enable, wheel_left, wheel_right, active_src, fault
  );
  modport slave (
    input  run, src_req, src_valid, cmd_left_0, cmd_left_1, cmd_left_2,
           cmd_right_0, cmd_right_1, cmd_right_2,
    output src_enable, wheel_left, wheel_right, active_src, fault
  );
endinterface

// File: rtl/drive_arbiter_slew_limiter.sv
// drive_arbiter_slew_limiter: moves one wheel output toward its target by at most STEP per tick
module drive_arbiter_slew_limiter #(
  parameter int W    = 8,
  parameter int STEP = 4
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                tick_i,
  input  logic                zero_i,
  input  logic signed [W-1:0] target_i,
  output logic signed [W-1:0] out_o
);
  localparam logic signed [W:0] S = (W+1)'(STEP);
  logic signed [W:0]   tgt_x, out_x, diff, nxt;
  logic signed [W-1:0] out_q, out_d;
  always_comb begin
    tgt_x = $signed({target_i[W-1], target_i});
    out_x = $signed({out_q[W-1], out_q});
    diff  = tgt_x - out_x;
    nxt   = diff > S ? out_x + S : diff < -S ? out_x - S : tgt_x;
    out_d = zero_i ? '0 : tick_i ? nxt[W-1:0] : out_q;
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) out_q <= '0;
    else          out_q <= out_d;
  assign out_o = out_q;
endmodule

// File: rtl/drive_arbiter.sv
// drive_arbiter: fixed-priority grant of the wheel outputs to one of three controllers,
// with slew-limited handover and a watchdog that forces a stop.
module drive_arbiter
  import drive_arbiter_pkg::*;
#(
  parameter int WIDTH_CMD   = WHEEL_W,
  parameter int SLEW_STEP   = 4,
  parameter int STEP_PERIOD = 2,
  parameter int TIMEOUT     = 1000,
  parameter int CMD_LIMIT   = 127
) (
  input logic            clk,
  input logic            reset_n,
  drive_arbiter_if.slave bus
);
  localparam int TW = $clog2(STEP_PERIOD + 1);
  localparam int WW = $clog2(TIMEOUT);
  typedef logic signed [WIDTH_CMD-1:0] wcmd_t;
  localparam wcmd_t LIM = wcmd_t'(CMD_LIMIT);
  state_t        state_q, state_d;
  logic [1:0]    act_q, act_d, win;
  logic [2:0]    en_q, en_d;
  wcmd_t         tgt_l_q, tgt_l_d, tgt_r_q, tgt_r_d, out_l, out_r;
  wcmd_t         cmd_l [3];
  wcmd_t         cmd_r [3];
  logic [WW-1:0] wd_q, wd_d;
  logic [TW-1:0] tick_q;
  logic          fault_q, tick, has_win, valid, hp, leave, expire, zero, force_zero;
  function automatic wcmd_t sat(input wcmd_t c);
    return c > LIM ? LIM : c < -LIM ? -LIM : c;
  endfunction
  assign cmd_l = '{bus.cmd_left_0, bus.cmd_left_1, bus.cmd_left_2};
  assign cmd_r = '{bus.cmd_right_0, bus.cmd_right_1, bus.cmd_right_2};
  assign has_win = |bus.src_req;
  assign win = bus.src_req[0] ? SRC_MANUAL : bus.src_req[1] ? SRC_AVOID :
               bus.src_req[2] ? SRC_CRUISE : SRC_NONE;
  // Any request below the granted index outranks the current owner.
  assign hp     = |(bus.src_req & ((3'b1 << act_q) - 3'b1));
  assign valid  = state_q == RUN && bus.src_valid[act_q];
  assign leave  = !bus.run || !bus.src_req[act_q] || hp;
  assign expire = !valid && wd_q == WW'(TIMEOUT - 1);
  assign zero   = out_l == '0 && out_r == '0;
  assign tick   = tick_q == TW'(STEP_PERIOD - 1);
  always_comb begin
    state_d = state_q;
    act_d   = act_q;
    en_d    = en_q;
    tgt_l_d = '0;
    tgt_r_d = '0;
    wd_d    = '0;
    case (state_q)
      IDLE, SWITCH: begin
        act_d = SRC_NONE;
        en_d  = '0;
        if (zero) begin
          state_d = bus.run && has_win ? RUN : IDLE;
          act_d   = bus.run && has_win ? win : SRC_NONE;
          en_d    = bus.run && has_win ? 3'b1 << win : 3'b0;
        end
      end
      RUN: begin
        wd_d    = valid ? '0 : wd_q + 1'b1;
        tgt_l_d = valid ? sat(cmd_l[act_q]) : tgt_l_q;
        tgt_r_d = valid ? sat(cmd_r[act_q]) : tgt_r_q;
        state_d = expire ? FAULT : leave ? SWITCH : RUN;
        if (expire || leave) begin
          act_d   = SRC_NONE;
          en_d    = '0;
          tgt_l_d = '0;
          tgt_r_d = '0;
          wd_d    = '0;
        end
      end
      default: begin
        act_d   = SRC_NONE;
        en_d    = '0;
        state_d = bus.run ? FAULT : IDLE;
      end
    endcase
  end
  // Entering or holding FAULT zeroes the wheels at once instead of ramping.
  assign force_zero = state_d == FAULT;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state_q <= IDLE;
      act_q   <= SRC_NONE;
      en_q    <= '0;
      tgt_l_q <= '0;
      tgt_r_q <= '0;
      wd_q    <= '0;
      tick_q  <= '0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      act_q   <= act_d;
      en_q    <= en_d;
      tgt_l_q <= tgt_l_d;
      tgt_r_q <= tgt_r_d;
      wd_q    <= wd_d;
      tick_q  <= tick ? '0 : tick_q + 1'b1;
      fault_q <= force_zero;
    end
  drive_arbiter_slew_limiter #(.W(WIDTH_CMD), .STEP(SLEW_STEP)) u_slew_l (
    .clk(clk), .reset_n(reset_n), .tick_i(tick), .zero_i(force_zero),
    .target_i(tgt_l_q), .out_o(out_l)
  );
  drive_arbiter_slew_limiter #(.W(WIDTH_CMD), .STEP(SLEW_STEP)) u_slew_r (
    .clk(clk), .reset_n(reset_n), .tick_i(tick), .zero_i(force_zero),
    .target_i(tgt_r_q), .out_o(out_r)
  );
  assign bus.src_enable  = en_q;
  assign bus.active_src  = act_q;
  assign bus.fault       = fault_q;
  assign bus.wheel_left  = out_l;
  assign bus.wheel_right = out_r;
endmodule
